// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (DIV/DIVU) for the EXE stage.
// Raises stallreq_exe while iterating and holds the result in DONE until EXE
// is released by the stall control unit (stall_exe low).
// Optional build macro: DIV_EARLY_EXIT_EN -- when |src1| < |src2| (nonzero
// divisor), skip the iterations and finish in one cycle.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              div_annul,
  input  logic              stall_exe,
  output logic              stallreq_exe,
  output logic              div_ready,
  output logic [DATA_W-1:0] div_hi,
  output logic [DATA_W-1:0] div_lo
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvsr;          // latched |src2|
  logic [2*DATA_W:0] wr;            // {rem, quo} working register
  logic [2*DATA_W:0] sh, wr_step;
  logic [DATA_W:0]   diff;
  logic              sign_q, sign_r;
  logic              neg1, neg2, early, last_step;
  logic [DATA_W-1:0] abs1, abs2, quo_fin, rem_fin;

  // Operand magnitudes; signs only matter for DIV.
  assign neg1 = div_signed & div_src1[DATA_W-1];
  assign neg2 = div_signed & div_src2[DATA_W-1];
  assign abs1 = neg1 ? -div_src1 : div_src1;
  assign abs2 = neg2 ? -div_src2 : div_src2;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (abs2 != '0) && (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  // One restoring step: shift left, trial-subtract the divisor from the
  // remainder half, keep the difference and set the quotient bit if it fits.
  always_comb begin
    sh      = wr << 1;
    diff    = sh[2*DATA_W:DATA_W] - {1'b0, dvsr};
    wr_step = sh;
    if (!diff[DATA_W]) wr_step = {diff, sh[DATA_W-1:1], 1'b1};
  end

  assign quo_fin = wr_step[DATA_W-1:0];
  assign rem_fin = wr_step[2*DATA_W-1:DATA_W];

  // State register.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and stall request; annul overrides everything.
  always_comb begin
    state_nxt    = state;
    stallreq_exe = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          stallreq_exe = 1'b1;
          if (abs2 == '0) state_nxt = DIVZERO;
          else if (early) state_nxt = DONE;
          else            state_nxt = BUSY;
        end
      end
      DIVZERO: begin
        stallreq_exe = 1'b1;
        state_nxt    = DONE;
      end
      BUSY: begin
        stallreq_exe = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (!stall_exe) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (div_annul) begin
      state_nxt    = IDLE;
      stallreq_exe = 1'b0;
    end
  end

  // Datapath: latch operands on start, iterate while busy.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      cnt    <= '0;
      wr     <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start && !div_annul) begin
            wr     <= {{(DATA_W+1){1'b0}}, abs1};
            dvsr   <= abs2;
            sign_q <= neg1 ^ neg2;
            sign_r <= neg1;
            cnt    <= '0;
          end
        end
        BUSY: begin
          wr  <= wr_step;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load only on entry to DONE; ready tracks DONE.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      div_ready <= 1'b0;
      div_hi    <= '0;
      div_lo    <= '0;
    end else begin
      div_ready <= (state_nxt == DONE);
      if (state != DONE && state_nxt == DONE) begin
        case (state)
          IDLE: begin
            div_lo <= '0;
            div_hi <= div_src1;
          end
          DIVZERO: begin
            // Undo the magnitude to hand back the raw dividend.
            div_lo <= '1;
            div_hi <= sign_r ? -wr[DATA_W-1:0] : wr[DATA_W-1:0];
          end
          default: begin
            div_lo <= sign_q ? -quo_fin : quo_fin;
            div_hi <= sign_r ? -rem_fin : rem_fin;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized + directed checks of div_unit against an
// arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, sgn, annul, stall;
  logic [31:0] a, b;
  logic        stallreq_exe, div_ready;
  logic [31:0] div_hi, div_lo;

  int errs = 0;
  int checks = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .div_start   (start),
    .div_signed  (sgn),
    .div_src1    (a),
    .div_src2    (b),
    .div_annul   (annul),
    .stall_exe   (stall),
    .stallreq_exe(stallreq_exe),
    .div_ready   (div_ready),
    .div_hi      (div_hi),
    .div_lo      (div_lo)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic; signed via 64-bit so MIN/-1 wraps naturally.
  function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r, output int stalls);
    longint sx, sy;
    if (y == 32'd0) begin
      q = '1; r = x; stalls = 2;
      return;
    end
    if (s) begin
      sx = $signed(x); sy = $signed(y);
      q = 32'(sx / sy); r = 32'(sx % sy);
    end else begin
      q = x / y; r = x % y;
    end
    stalls = 33;
`ifdef DIV_EARLY_EXIT_EN
    begin
      logic [31:0] mx, my;
      mx = (s && x[31]) ? -x : x;
      my = (s && y[31]) ? -y : y;
      if (mx < my) stalls = 1;
    end
`endif
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] q, r;
    int st, n, cyc;
    bit seen;
    model(s, x, y, q, r, st);
    @(negedge clk);
    start = 1'b1; sgn = s; a = x; b = y; stall = 1'b1;
    n = 0; cyc = 0; seen = 0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (div_ready) begin seen = 1; cyc = i; break; end
      if (stallreq_exe) n++;
      @(negedge clk);
    end
    chk({tag, " ready"}, 32'(seen), 32'd1);
    chk({tag, " stalls"}, n, st);
    chk({tag, " ready_cyc"}, cyc, st);
    chk({tag, " lo"}, div_lo, q);
    chk({tag, " hi"}, div_hi, r);
    chk({tag, " req_done"}, 32'(stallreq_exe), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      chk({tag, " hold_ready"}, 32'(div_ready), 32'd1);
      chk({tag, " hold_lo"}, div_lo, q);
    end
    stall = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    chk({tag, " ready_fall"}, 32'(div_ready), 32'd0);
    chk({tag, " keep_hi"}, div_hi, r);
  endtask

  initial begin
    int rises;
    logic s;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; stall = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst ready", 32'(div_ready), 32'd0);
    chk("rst req", 32'(stallreq_exe), 32'd0);
    chk("rst hi", div_hi, 32'd0);
    chk("rst lo", div_lo, 32'd0);
    rst = 1'b0;

    run_op("divu100_7", 1'b0, 32'd100, 32'd7, 0);
    run_op("div-7_2", 1'b1, -32'sd7, 32'd2, 1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu5_0", 1'b0, 32'd5, 32'd0, 0);
    run_op("div-5_0", 1'b1, -32'sd5, 32'd0, 2);
    run_op("divu9_4", 1'b0, 32'd9, 32'd4, 5);
    run_op("divu3_10", 1'b0, 32'd3, 32'd10, 0);
    run_op("div-3_10", 1'b1, -32'sd3, 32'd10, 0);
    run_op("divu100_7b", 1'b0, 32'd100, 32'd7, 0);

    // Annul in the middle of an operation: stale outputs from 100/7 remain.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3; stall = 1'b1;
    for (int i = 0; i < 11; i++) @(negedge clk);
    annul = 1'b1; #1;
    chk("annul req", 32'(stallreq_exe), 32'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0; stall = 1'b0; #1;
    chk("annul idle_req", 32'(stallreq_exe), 32'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (div_ready) rises++;
    end
    chk("annul no_ready", rises, 0);
    chk("annul stale_lo", div_lo, 32'd14);
    chk("annul stale_hi", div_hi, 32'd2);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5; stall = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("midrst req", 32'(stallreq_exe), 32'd0);
    chk("midrst ready", 32'(div_ready), 32'd0);
    chk("midrst lo", div_lo, 32'd0);
    chk("midrst hi", div_hi, 32'd0);
    stall = 1'b0;

    // Randomized operations.
    for (int t = 0; t < 30; t++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = $urandom; y = $urandom_range(1, 300); end
        2: begin x = $urandom_range(0, 50); y = $urandom; end
        3: begin x = $urandom; y = 32'd0; end
        default: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      endcase
      if ($urandom_range(0, 3) == 0) y = -y;
      run_op("rand", s, x, y, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
